ram_datos: RTL and testbench

RAM_DATOS -- requirements
Module: ram_datos

---
 rtl/ram_datos.sv | 203 ++++++++++++++++++++
 tb/tb_ram_datos.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_datos.sv
// Data RAM for the core's load/store unit. A request is accepted in
// IDLE, held for WAIT_CYCLES wait states, and the array is accessed in
// DONE with a one-cycle ready strobe. Sub-word stores are byte-lane masked;
// loads are sign- or zero-extended. Misaligned or unsupported accesses
// are rejected with err and leave the array untouched.
module ram_datos #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        ena_rd,
  input  logic        ena_wr,
  input  logic [31:0] addr,
  input  logic [31:0] dataram_wr,
  input  logic [2:0]  funct3,
  output logic [31:0] data_rd,
  output logic        ready,
  output logic        err
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [3:0]      cnt_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic [2:0]      f3_r;
  logic            wr_r;
  logic            accept_s;
  logic [AW-1:0]   idx_s;
  logic [1:0]      off_s;
  logic            access_err_s;
  logic [31:0]     rd_word_s;
  logic [3:0]      lane_en_s;
  logic [31:0]     lane_data_s;
  logic            ready_nx_s;
  logic            err_nx_s;
  logic [31:0]     data_nx_s;
  logic            unused_addr_s;
  logic [31:0]     mem_r [DEPTH_WORDS];

  // Rejects misaligned halves/words, unknown sizes and unsigned-size stores.
  function automatic logic access_error(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = (off != 2'b00);
      3'b100:  e = is_store;
      3'b101:  e = is_store | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicates the low byte/half of the store data across all lanes.
  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Selects the addressed byte/half of a word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s      = (state_r == IDLE) && (ena_rd || ena_wr);
  assign idx_s         = addr_r[AW+1:2];
  assign off_s         = addr_r[1:0];
  assign access_err_s  = access_error(f3_r, off_s, wr_r);
  assign rd_word_s     = mem_r[idx_s];
  assign lane_en_s     = byte_enables(f3_r, off_s);
  assign lane_data_s   = store_align(f3_r, wdata_r);
  // Upper address bits wrap around and are intentionally dropped.
  assign unused_addr_s = ^addr[31:AW+2];

  // State register, wait counter and request capture.
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      f3_r    <= 3'd0;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        cnt_r   <= WAIT_LD;
        addr_r  <= addr[AW+1:0];
        wdata_r <= dataram_wr;
        f3_r    <= funct3;
        wr_r    <= ena_wr;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) DONE -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = (WAIT_LD == 4'd0) ? DONE : WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Response values computed in DONE; data_rd only moves on loads.
  always_comb begin
    ready_nx_s = 1'b0;
    err_nx_s   = 1'b0;
    data_nx_s  = data_rd;
    if (state_r == DONE) begin
      ready_nx_s = 1'b1;
      err_nx_s   = access_err_s;
      if (!wr_r) begin
        data_nx_s = access_err_s ? 32'd0 : load_extend(f3_r, rd_word_s, off_s);
      end else begin
        data_nx_s = data_rd;
      end
    end else begin
      data_nx_s = data_rd;
    end
  end

  // Registered response outputs.
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      ready   <= 1'b0;
      err     <= 1'b0;
      data_rd <= 32'd0;
    end else begin
      ready   <= ready_nx_s;
      err     <= err_nx_s;
      data_rd <= data_nx_s;
    end
  end

  // Lane-masked array write in DONE; never touched while reset is low.
  always_ff @(posedge CLOCK) begin
    if (RST_n && (state_r == DONE) && wr_r && !access_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= lane_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_datos.sv
// Scoreboard bench for ram_datos: directed requests push their expected
// response (data, err, arrival cycle); a negedge monitor pops and compares
// on every ready strobe. A second instance with WAIT_CYCLES=3 covers
// back-to-back requests while busy.
module tb_ram_datos;

  logic        clk;
  logic        rst_n;
  logic        ena_rd, ena_wr;
  logic [31:0] addr, dataram_wr;
  logic [2:0]  funct3;
  logic [31:0] data_rd;
  logic        ready, err;

  logic        b_rst_n, b_rd, b_wr;
  logic [31:0] b_addr, b_wdata, b_data;
  logic [2:0]  b_f3;
  logic        b_ready, b_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        chk_d;
    int          c;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  ram_datos #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .CLOCK(clk), .RST_n(rst_n), .ena_rd(ena_rd), .ena_wr(ena_wr),
    .addr(addr), .dataram_wr(dataram_wr), .funct3(funct3),
    .data_rd(data_rd), .ready(ready), .err(err)
  );

  ram_datos #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut_b (
    .CLOCK(clk), .RST_n(b_rst_n), .ena_rd(b_rd), .ena_wr(b_wr),
    .addr(b_addr), .dataram_wr(b_wdata), .funct3(b_f3),
    .data_rd(b_data), .ready(b_ready), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each ready strobe against the scoreboard head.
  always @(negedge clk) begin
    exp_t x;
    if (ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected none", cyc);
      end else begin
        x = sb_q.pop_front();
        checks++;
        if (cyc != x.c) begin
          errors++;
          $display("FAIL %s latency: got cycle %0d, expected %0d", x.name, cyc, x.c);
        end
        checks++;
        if (err !== x.e) begin
          errors++;
          $display("FAIL %s err: got %b, expected %b", x.name, err, x.e);
        end
        if (x.chk_d) begin
          checks++;
          if (data_rd !== x.d) begin
            errors++;
            $display("FAIL %s data: got %h, expected %h", x.name, data_rd, x.d);
          end
        end
      end
    end else if (err !== 1'b0) begin
      checks++; errors++;
      $display("FAIL err_without_ready: got err=%b, expected 0", err);
    end
  end

  task automatic req(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input logic chk_d);
    exp_t x;
    @(negedge clk);
    ena_rd = rd; ena_wr = wr; funct3 = f3; addr = a; dataram_wr = d;
    x.d = exp_d; x.e = exp_e; x.chk_d = chk_d; x.c = cyc + 3; x.name = name;
    sb_q.push_back(x);
    @(negedge clk);
    ena_rd = 1'b0; ena_wr = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no ready in 20 cycles, expected ready", name);
      sb_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  int ready_cnt;
  int first_c;
  int last_c;

  initial begin
    rst_n = 1'b0; ena_rd = 1'b0; ena_wr = 1'b0; addr = 32'd0; dataram_wr = 32'd0; funct3 = 3'd0;
    b_rst_n = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_f3 = 3'b010;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_data_rd", data_rd, 32'd0);
    check_val("reset_ready", {31'd0, ready}, 32'd0);
    check_val("reset_err", {31'd0, err}, 32'd0);

    // Word round-trip.
    req("sw_10",  1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
    req("lw_10",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    // Byte lanes and extension.
    req("sw_0",   1'b0, 1'b1, 3'b010, 32'h0,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    req("sb_3",   1'b0, 1'b1, 3'b000, 32'h3,  32'h12345680, 32'hDEADBEEF, 1'b0, 1'b1);
    req("lw_0",   1'b1, 1'b0, 3'b010, 32'h0,  32'h0,        32'h80000000, 1'b0, 1'b1);
    req("lb_3",   1'b1, 1'b0, 3'b000, 32'h3,  32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
    req("lbu_3",  1'b1, 1'b0, 3'b100, 32'h3,  32'h0,        32'h00000080, 1'b0, 1'b1);
    // Misaligned half load.
    req("sw_4",   1'b0, 1'b1, 3'b010, 32'h4,  32'h11223344, 32'h00000080, 1'b0, 1'b1);
    req("lh_5",   1'b1, 1'b0, 3'b001, 32'h5,  32'h0,        32'h0,        1'b1, 1'b1);
    req("lw_4",   1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        32'h11223344, 1'b0, 1'b1);
    // Half stores / loads on the upper and lower lanes.
    req("sh_6",   1'b0, 1'b1, 3'b001, 32'h6,  32'hABCDBEEF, 32'h11223344, 1'b0, 1'b1);
    req("lh_6",   1'b1, 1'b0, 3'b001, 32'h6,  32'h0,        32'hFFFFBEEF, 1'b0, 1'b1);
    req("lhu_6",  1'b1, 1'b0, 3'b101, 32'h6,  32'h0,        32'h0000BEEF, 1'b0, 1'b1);
    req("lh_4",   1'b1, 1'b0, 3'b001, 32'h4,  32'h0,        32'h00003344, 1'b0, 1'b1);
    req("sb_5",   1'b0, 1'b1, 3'b000, 32'h5,  32'h0000007F, 32'h00003344, 1'b0, 1'b1);
    req("lw_4b",  1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        32'hBEEF7F44, 1'b0, 1'b1);
    req("lb_5",   1'b1, 1'b0, 3'b000, 32'h5,  32'h0,        32'h0000007F, 1'b0, 1'b1);
    // Rejected accesses: no array write.
    req("sbu_4",  1'b0, 1'b1, 3'b100, 32'h4,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    req("s011_4", 1'b0, 1'b1, 3'b011, 32'h4,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    req("sw_6",   1'b0, 1'b1, 3'b010, 32'h6,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    req("lw_4c",  1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        32'hBEEF7F44, 1'b0, 1'b1);
    req("lw_2",   1'b1, 1'b0, 3'b010, 32'h2,  32'h0,        32'h0,        1'b1, 1'b1);
    req("l011_4", 1'b1, 1'b0, 3'b011, 32'h4,  32'h0,        32'h0,        1'b1, 1'b1);
    // Wrap-around and write priority.
    req("sw_wrap",1'b1, 1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5, 32'h0,      1'b0, 1'b1);
    req("lw_wrap",1'b1, 1'b0, 3'b010, 32'h0,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b1);

    // Reset during WAIT discards the store.
    req("sw_20",  1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0, 1'b1);
    req("lw_20",  1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
    @(negedge clk);
    ena_wr = 1'b1; funct3 = 3'b010; addr = 32'h20; dataram_wr = 32'h12345678;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ena_wr = 1'b0;
    repeat (4) @(negedge clk);
    check_val("reset_mid_data_rd", data_rd, 32'd0);
    req("lw_20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);

    // Busy handling on the WAIT_CYCLES=3 instance: continuous load requests.
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    b_rd = 1'b1;
    ready_cnt = 0; first_c = 0; last_c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b_ready) begin
        if (ready_cnt == 0) begin
          first_c = i;
        end else begin
          check_val("busy_gap", i - last_c, 32'd5);
        end
        check_val("busy_err", {31'd0, b_err}, 32'd0);
        last_c = i;
        ready_cnt++;
      end
    end
    b_rd = 1'b0;
    check_val("busy_first", first_c, 32'd5);
    check_val("busy_count", ready_cnt, 32'd4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
